// File: rtl/bist_seq_pkg.sv
// Shared types and constants for the BIST session sequencer.
//   state_t     : sequencer FSM states
//   IDX_W       : session index / session count width
//   rec_*       : result record layout {idx, error, timeout, cycles}
//   DEF_*       : default parameter values
//   EXP_CYCLES  : cycle count reported by a fault-free wrapper session
package bist_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LAUNCH,
    S_WAIT,
    S_PUSH
  } state_t;

  localparam int unsigned IDX_W       = 4;
  localparam int unsigned FLAG_W      = 2;
  localparam int unsigned DEF_CNT_W   = 10;
  localparam int unsigned DEF_TIMEOUT = 600;
  localparam int unsigned DEF_DEPTH   = 4;
  localparam int unsigned DEF_CLR_CYC = 2;
  localparam int unsigned EXP_CYCLES  = 513;

  // Record layout: cycles occupy [cnt_w-1:0], flags sit above, index on top.
  function automatic int unsigned rec_width(int unsigned cnt_w);
    return cnt_w + FLAG_W + IDX_W;
  endfunction

  function automatic int unsigned rec_to_bit(int unsigned cnt_w);
    return cnt_w;
  endfunction

  function automatic int unsigned rec_err_bit(int unsigned cnt_w);
    return cnt_w + 1;
  endfunction

endpackage

// File: rtl/bist_session_sequencer_if.sv
// Host + wrapper-facing signal bundle of the BIST session sequencer.
//   master : sequencer side (drives test_mode, bist_reset, status, record port)
//   slave  : host / wrapper side
interface bist_session_sequencer_if
  import bist_seq_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
);

  localparam int unsigned REC_W = rec_width(CNT_W);

  logic             start;
  logic [IDX_W-1:0] num_sessions;
  logic             test_mode;
  logic             bist_reset;
  logic             bist_done;
  logic             bist_error;
  logic             busy;
  logic             fail_seen;
  logic             rec_valid;
  logic             rec_ready;
  logic [REC_W-1:0] rec_data;

  modport master (
    input  start, num_sessions, bist_done, bist_error, rec_ready,
    output test_mode, bist_reset, busy, fail_seen, rec_valid, rec_data
  );

  modport slave (
    output start, num_sessions, bist_done, bist_error, rec_ready,
    input  test_mode, bist_reset, busy, fail_seen, rec_valid, rec_data
  );

endinterface

// File: rtl/bist_rec_fifo.sv
// Small result-record FIFO with wrap-bit pointers.
//   clk, rst_n : clock, async active-low reset (flushes contents)
//   push/wdata : write request (accepted when not full, or full with a pop)
//   pop        : read request (ignored when empty)
//   full_c     : FIFO full
//   valid_c    : FIFO non-empty
//   head_c     : entry at the head, stable until popped
module bist_rec_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full_c,
  output logic             valid_c,
  output logic [WIDTH-1:0] head_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             empty_c;
  logic             do_pop_c;
  logic             do_push_c;

  // Equal low bits with differing wrap bits means the writer lapped the reader.
  assign empty_c   = (wr_ptr == rd_ptr);
  assign full_c    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign valid_c   = !empty_c;
  assign do_pop_c  = pop && !empty_c;
  assign do_push_c = push && (!full_c || do_pop_c);
  assign head_c    = mem[rd_ptr[AW-1:0]];

  // Storage and pointers; memory cleared on reset so the head reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push_c) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop_c) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/bist_session_sequencer.sv
// Runs a programmed number of back-to-back BIST sessions on the adder
// wrapper, re-initialising it before each one, timing each session and
// queueing a {idx, error, timeout, cycles} record per session.
//   clock, reset : clock, async active-low reset
//   bus.start / bus.num_sessions : session request (sampled in IDLE)
//   bus.test_mode / bus.bist_reset : registered wrapper controls
//   bus.bist_done / bus.bist_error : wrapper status
//   bus.busy / bus.fail_seen : sequencer status
//   bus.rec_valid / bus.rec_ready / bus.rec_data : record drain port
module bist_session_sequencer
  import bist_seq_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned CLR_CYC = DEF_CLR_CYC
) (
  input logic                      clock,
  input logic                      reset,
  bist_session_sequencer_if.master bus
);

  localparam int unsigned REC_W   = rec_width(CNT_W);
  localparam int unsigned TO_BIT  = rec_to_bit(CNT_W);
  localparam int unsigned ERR_BIT = rec_err_bit(CNT_W);
  localparam int unsigned CLR_W   = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc_c;
  logic [IDX_W-1:0] idx, idx_nxt, idx_inc_c;
  logic [IDX_W-1:0] n_lat, n_lat_nxt;
  logic [CLR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic             test_mode_q, test_mode_nxt;
  logic             bist_reset_q, bist_reset_nxt;
  logic             busy_q, busy_nxt;
  logic             fail_q, fail_nxt;
  logic [REC_W-1:0] rec_q, rec_nxt;
  logic             push_c;
  logic             fifo_full_c;
  logic             fifo_valid_c;
  logic [REC_W-1:0] fifo_head_c;

  assign cnt_inc_c = cnt + CNT_W'(1);
  assign idx_inc_c = idx + IDX_W'(1);

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      idx          <= '0;
      n_lat        <= '0;
      clr_cnt      <= '0;
      test_mode_q  <= 1'b0;
      bist_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      fail_q       <= 1'b0;
      rec_q        <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      idx          <= idx_nxt;
      n_lat        <= n_lat_nxt;
      clr_cnt      <= clr_cnt_nxt;
      test_mode_q  <= test_mode_nxt;
      bist_reset_q <= bist_reset_nxt;
      busy_q       <= busy_nxt;
      fail_q       <= fail_nxt;
      rec_q        <= rec_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    idx_nxt        = idx;
    n_lat_nxt      = n_lat;
    clr_cnt_nxt    = clr_cnt;
    test_mode_nxt  = test_mode_q;
    bist_reset_nxt = bist_reset_q;
    fail_nxt       = fail_q;
    rec_nxt        = rec_q;
    push_c         = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (bus.start && (bus.num_sessions != '0)) begin
          n_lat_nxt      = bus.num_sessions;
          idx_nxt        = '0;
          fail_nxt       = 1'b0;
          clr_cnt_nxt    = '0;
          bist_reset_nxt = 1'b0;
          state_nxt      = S_CLEAR;
        end
      end

      S_CLEAR: begin
        if (clr_cnt == CLR_W'(CLR_CYC - 1)) begin
          bist_reset_nxt = 1'b1;
          state_nxt      = S_LAUNCH;
        end else begin
          clr_cnt_nxt = clr_cnt + CLR_W'(1);
        end
      end

      S_LAUNCH: begin
        test_mode_nxt = 1'b1;
        cnt_nxt       = '0;
        state_nxt     = S_WAIT;
      end

      // Done takes priority over a timeout landing on the same edge.
      S_WAIT: begin
        cnt_nxt = cnt_inc_c;
        if (bus.bist_done) begin
          rec_nxt       = {idx, bus.bist_error, 1'b0, cnt_inc_c};
          test_mode_nxt = 1'b0;
          state_nxt     = S_PUSH;
        end else if (cnt_inc_c == CNT_W'(TIMEOUT)) begin
          rec_nxt       = {idx, bus.bist_error, 1'b1, CNT_W'(TIMEOUT)};
          test_mode_nxt = 1'b0;
          state_nxt     = S_PUSH;
        end
      end

      // Stalls while the FIFO is full; the wrapper idles with test_mode low.
      S_PUSH: begin
        if (!fifo_full_c) begin
          push_c = 1'b1;
          if (rec_q[TO_BIT] || rec_q[ERR_BIT]) begin
            fail_nxt = 1'b1;
          end
          if (idx_inc_c == n_lat) begin
            state_nxt = S_IDLE;
          end else begin
            idx_nxt        = idx_inc_c;
            clr_cnt_nxt    = '0;
            bist_reset_nxt = 1'b0;
            state_nxt      = S_CLEAR;
          end
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

  bist_rec_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (reset),
    .push    (push_c),
    .wdata   (rec_q),
    .pop     (bus.rec_ready),
    .full_c  (fifo_full_c),
    .valid_c (fifo_valid_c),
    .head_c  (fifo_head_c)
  );

  assign bus.test_mode  = test_mode_q;
  assign bus.bist_reset = bist_reset_q;
  assign bus.busy       = busy_q;
  assign bus.fail_seen  = fail_q;
  assign bus.rec_valid  = fifo_valid_c;
  assign bus.rec_data   = fifo_head_c;

endmodule

// File: tb/tb_bist_session_sequencer.sv
// Bench for bist_session_sequencer: a behavioural wrapper stub with
// per-session done latency / error, and a queue of expected records built
// from the session rules (latency vs timeout, done priority, idx order).
module tb_bist_session_sequencer;
  import bist_seq_pkg::*;

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned TIMEOUT = 600;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CLR_CYC = 2;
  localparam int unsigned REC_W   = rec_width(CNT_W);
  localparam int          NEVER   = 1000;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  bist_session_sequencer_if #(.CNT_W(CNT_W)) bus ();

  bist_session_sequencer #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT),
    .DEPTH   (DEPTH),
    .CLR_CYC (CLR_CYC)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Wrapper stub: done after sess_lat test_mode edges, error per session,
  // sticky error until bist_reset is pulled low.
  int   sess_lat [16];
  bit   sess_err [16];
  int   clears = 0;
  int   base   = 0;
  int   tcnt   = 0;
  int   sidx;
  int   br_low = 0;
  logic err_sticky = 1'b0;
  logic br_q = 1'b1;

  always_comb sidx = (clears - base - 1) & 15;

  always @(posedge clock) begin
    br_q <= bus.bist_reset;
    if (!bus.bist_reset && br_q) clears <= clears + 1;
    if (!bus.bist_reset) br_low <= br_low + 1;
    if (!bus.bist_reset) begin
      tcnt       <= 0;
      err_sticky <= 1'b0;
    end else if (bus.test_mode) begin
      tcnt <= tcnt + 1;
      if (sess_err[sidx]) err_sticky <= 1'b1;
    end
  end

  assign bus.bist_done  = bus.test_mode && (tcnt == sess_lat[sidx] - 1);
  assign bus.bist_error = err_sticky || (bus.test_mode && sess_err[sidx]);

  // Expected records and host model.
  logic [REC_W-1:0] exp_q [$];
  int ready_mode = 0;   // 0: always ready, 1: never ready, 2: random

  function automatic logic [REC_W-1:0] mk_rec(int idx, int lat, bit err);
    bit to;
    int cyc;
    if (lat <= int'(TIMEOUT)) begin
      to  = 1'b0;
      cyc = lat;
    end else begin
      to  = 1'b1;
      cyc = int'(TIMEOUT);
    end
    return {IDX_W'(idx), err, to, CNT_W'(cyc)};
  endfunction

  always @(negedge clock) begin
    case (ready_mode)
      0:       bus.rec_ready = 1'b1;
      1:       bus.rec_ready = 1'b0;
      default: bus.rec_ready = 1'($urandom_range(0, 1));
    endcase
    if (reset && bus.rec_valid) begin
      check_eq("rec_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check_eq("rec_data", 32'(bus.rec_data), 32'(exp_q[0]));
        if (bus.rec_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic start_run(int n);
    base = clears;
    @(negedge clock);
    bus.start        = 1'b1;
    bus.num_sessions = IDX_W'(n);
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(output int dur);
    dur = 0;
    do begin
      @(posedge clock);
      dur++;
      @(negedge clock);
    end while (bus.busy && dur < 20000);
    if (bus.busy) check_eq("idle_bound", 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_drain(string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      @(posedge clock);
      k++;
    end
    check_eq({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_run(string tag, int n, int rmode);
    int exp_dur;
    int dur;
    bit exp_fail;
    int br0;
    exp_dur  = 0;
    exp_fail = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mk_rec(i, sess_lat[i], sess_err[i]));
      exp_dur += int'(CLR_CYC) + 2 + ((sess_lat[i] < int'(TIMEOUT)) ? sess_lat[i] : int'(TIMEOUT));
      if (sess_err[i] || sess_lat[i] > int'(TIMEOUT)) exp_fail = 1'b1;
    end
    ready_mode = rmode;
    br0 = br_low;
    start_run(n);
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'd1);
    check_eq({tag, "_fail_clr"}, 32'(bus.fail_seen), 32'd0);
    wait_idle(dur);
    if (rmode == 0) check_eq({tag, "_dur"}, 32'(dur), 32'(exp_dur));
    check_eq({tag, "_fail"}, 32'(bus.fail_seen), 32'(exp_fail));
    check_eq({tag, "_clr_cyc"}, 32'(br_low - br0), 32'(int'(CLR_CYC) * n));
    wait_drain(tag);
  endtask

  task automatic set_sessions(int lat, bit err);
    for (int i = 0; i < 16; i++) begin
      sess_lat[i] = lat;
      sess_err[i] = err;
    end
  endtask

  initial begin
    int dur;
    int k;
    int n;
    bus.start        = 1'b0;
    bus.num_sessions = '0;
    set_sessions(int'(EXP_CYCLES), 1'b0);

    // Reset values
    #2 reset = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("rst_test_mode", 32'(bus.test_mode), 32'd0);
    check_eq("rst_bist_reset", 32'(bus.bist_reset), 32'd1);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_fail_seen", 32'(bus.fail_seen), 32'd0);
    check_eq("rst_rec_valid", 32'(bus.rec_valid), 32'd0);
    check_eq("rst_rec_data", 32'(bus.rec_data), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // num_sessions = 0 is ignored
    start_run(0);
    check_eq("zero_busy", 32'(bus.busy), 32'd0);
    check_eq("zero_bist_reset", 32'(bus.bist_reset), 32'd1);
    repeat (3) @(negedge clock);
    check_eq("zero_test_mode", 32'(bus.test_mode), 32'd0);

    // Single fault-free session, then three back to back
    do_run("single", 1, 0);
    do_run("three", 3, 0);

    // Sticky error from the second session onward
    set_sessions(1, 1'b1);
    sess_lat[0] = int'(EXP_CYCLES);
    sess_err[0] = 1'b0;
    do_run("error", 4, 0);

    // Timeout, then the done/timeout boundary
    set_sessions(NEVER, 1'b0);
    do_run("timeout", 1, 0);
    sess_lat[0] = int'(TIMEOUT);
    sess_lat[1] = int'(TIMEOUT) + 1;
    do_run("tboundary", 2, 0);

    // FIFO full stall
    set_sessions(int'(EXP_CYCLES), 1'b0);
    for (int i = 0; i < 6; i++) exp_q.push_back(mk_rec(i, int'(EXP_CYCLES), 1'b0));
    ready_mode = 1;
    start_run(6);
    repeat (5 * (int'(CLR_CYC) + 2 + int'(EXP_CYCLES)) + 100) @(posedge clock);
    @(negedge clock);
    check_eq("full_busy", 32'(bus.busy), 32'd1);
    check_eq("full_test_mode", 32'(bus.test_mode), 32'd0);
    check_eq("full_bist_reset", 32'(bus.bist_reset), 32'd1);
    check_eq("full_rec_valid", 32'(bus.rec_valid), 32'd1);
    check_eq("full_pending", 32'(exp_q.size()), 32'd6);
    ready_mode = 0;
    wait_idle(dur);
    check_eq("full_fail", 32'(bus.fail_seen), 32'd0);
    wait_drain("full");

    // Reset during WAIT of the second session
    for (int i = 0; i < 3; i++) exp_q.push_back(mk_rec(i, int'(EXP_CYCLES), 1'b0));
    ready_mode = 0;
    start_run(3);
    k = 0;
    while (!((clears - base) == 2 && bus.test_mode) && k < 3000) begin
      @(negedge clock);
      k++;
    end
    check_eq("mid_reach_s2", 32'((clears - base) == 2 && bus.test_mode), 32'd1);
    repeat (50) @(negedge clock);
    check_eq("mid_pending", 32'(exp_q.size()), 32'd2);
    reset = 1'b0;
    #1;
    check_eq("mid_test_mode", 32'(bus.test_mode), 32'd0);
    check_eq("mid_bist_reset", 32'(bus.bist_reset), 32'd1);
    check_eq("mid_busy", 32'(bus.busy), 32'd0);
    check_eq("mid_fail_seen", 32'(bus.fail_seen), 32'd0);
    check_eq("mid_rec_valid", 32'(bus.rec_valid), 32'd0);
    check_eq("mid_rec_data", 32'(bus.rec_data), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clock);
    reset = 1'b1;
    do_run("restart", 1, 0);

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < 16; i++) begin
        case ($urandom_range(0, 4))
          0:       sess_lat[i] = int'(EXP_CYCLES);
          1:       sess_lat[i] = $urandom_range(1, 30);
          2:       sess_lat[i] = $urandom_range(595, 605);
          3:       sess_lat[i] = NEVER;
          default: sess_lat[i] = $urandom_range(31, 200);
        endcase
        sess_err[i] = ($urandom_range(0, 3) == 0);
      end
      do_run("rand", n, 2 * int'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
